// File: rtl/gmii2fifo9.sv
// GMII receive to 9-bit FIFO writer: each received byte is written as {1, byte},
// and each frame is followed by Gap separator words of 9'h000.
module gmii2fifo9 #(
   parameter logic [3:0] Gap = 4'h2
) (
   input  logic       gmii_rx_clk,
   input  logic       sys_rst,
   input  logic       gmii_rx_dv,
   input  logic [7:0] gmii_rxd,
   output logic [8:0] din,
   input  logic       full,
   output logic       wr_en,
   output logic       wr_clk
);

   typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

   state_t     state_q, state_d;
   logic [3:0] gapCnt_q, gapCnt_d;
   logic [8:0] din_q, din_d;
   logic       wrEn_q, wrEn_d;

   assign wr_clk = gmii_rx_clk;
   assign din    = din_q;
   assign wr_en  = wrEn_q;

   // Once a frame overflows, the rest of it is discarded even if the FIFO drains;
   // the separator count is reloaded on entry so the truncated frame still gets terminated.
   always_comb begin
      state_d  = state_q;
      gapCnt_d = gapCnt_q;
      din_d    = din_q;
      wrEn_d   = 1'b0;
      if (gmii_rx_dv) begin
         if (state_q == DROP) begin
            state_d = DROP;
         end else if (full) begin
            state_d  = DROP;
            gapCnt_d = Gap;
         end else begin
            din_d    = {1'b1, gmii_rxd};
            wrEn_d   = 1'b1;
            gapCnt_d = Gap;
            state_d  = FRAME;
         end
      end else if (gapCnt_q == 4'd0) begin
         state_d = IDLE;
      end else begin
         if (state_q == DROP) begin
            state_d = FRAME;
         end
         if (!full) begin
            din_d    = 9'h000;
            wrEn_d   = 1'b1;
            gapCnt_d = gapCnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         gapCnt_q <= 4'd0;
         din_q    <= 9'h000;
         wrEn_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gapCnt_q <= gapCnt_d;
         din_q    <= din_d;
         wrEn_q   <= wrEn_d;
      end
   end

endmodule

// File: tb/tb_gmii2fifo9.sv
// Scoreboard bench for gmii2fifo9: stimulus pushes expected FIFO words, monitors pop
// and compare on every write. A second instance runs with Gap=0.
module tb_gmii2fifo9;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv0, full0, dv1, full1;
   logic [7:0] rxd0, rxd1;
   logic [8:0] din0, din1;
   logic       wrEn0, wrEn1, wrClk0, wrClk1;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   int         checks = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   gmii2fifo9 dut0 (
      .gmii_rx_clk(clk), .sys_rst(rst), .gmii_rx_dv(dv0), .gmii_rxd(rxd0),
      .din(din0), .full(full0), .wr_en(wrEn0), .wr_clk(wrClk0)
   );

   gmii2fifo9 #(.Gap(4'h0)) dut1 (
      .gmii_rx_clk(clk), .sys_rst(rst), .gmii_rx_dv(dv1), .gmii_rxd(rxd1),
      .din(din1), .full(full1), .wr_en(wrEn1), .wr_clk(wrClk1)
   );

   task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Drive one cycle into dut0; a written cycle expects {1,byte} or a 000 separator.
   task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic fl, input bit push);
      dv0 = dv; rxd0 = d; full0 = fl;
      if (push) q0.push_back(dv ? {1'b1, d} : 9'h000);
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus1(input logic dv, input logic [7:0] d, input bit push);
      dv1 = dv; rxd1 = d; full1 = 1'b0;
      if (push) q1.push_back(dv ? {1'b1, d} : 9'h000);
      @(posedge clk); #1;
   endtask

   task automatic drainCheck(input string name);
      checkOutput(name, 9'(q0.size() + q1.size()), 9'd0);
      q0.delete();
      q1.delete();
   endtask

   always @(negedge clk) begin
      if (wrEn0) begin
         if (q0.size() == 0) begin
            checks++;
            $display("[TB] FAIL write0: got unexpected write %h, expected no write", din0);
         end else begin
            checkOutput("write0", din0, q0.pop_front());
         end
      end
      if (wrEn1) begin
         if (q1.size() == 0) begin
            checks++;
            $display("[TB] FAIL write1: got unexpected write %h, expected no write", din1);
         end else begin
            checkOutput("write1", din1, q1.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      dv0 = 1'b0; rxd0 = 8'h00; full0 = 1'b0;
      dv1 = 1'b0; rxd1 = 8'h00; full1 = 1'b0;
      #3;
      checkOutput("rstWrEn", {8'h00, wrEn0}, 9'h000);
      checkOutput("rstDin", din0, 9'h000);
      checkOutput("wrClkLow", {8'h00, wrClk0}, {8'h00, clk});
      @(posedge clk); #1;
      checkOutput("wrClkHigh", {8'h00, wrClk0}, 9'h001);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic frame with preamble/SFD passthrough and first-write latency
      dv0 = 1'b1; rxd0 = 8'h55; full0 = 1'b0;
      q0.push_back(9'h155);
      checkOutput("preLatency", {8'h00, wrEn0}, 9'h000);
      @(posedge clk); #1;
      checkOutput("latency", {wrEn0, din0[7:0]}, 9'h155);
      applyStimulus(1, 8'h55, 0, 1);
      applyStimulus(1, 8'hD5, 0, 1);
      applyStimulus(1, 8'h01, 0, 1);
      applyStimulus(1, 8'h02, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      drainCheck("drainFrame");

      // Two frames separated by a single idle cycle
      applyStimulus(1, 8'hA1, 0, 1);
      applyStimulus(1, 8'hA2, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(1, 8'hB1, 0, 1);
      applyStimulus(1, 8'hB2, 0, 1);
      applyStimulus(1, 8'hB3, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      drainCheck("drainBackToBack");

      // Overflow on byte 3: remainder dropped even after full clears
      applyStimulus(1, 8'h10, 0, 1);
      applyStimulus(1, 8'h11, 0, 1);
      applyStimulus(1, 8'h12, 1, 0);
      applyStimulus(1, 8'h13, 0, 0);
      applyStimulus(1, 8'h14, 0, 0);
      applyStimulus(1, 8'h15, 0, 0);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      drainCheck("drainOverflow");

      // Full held during the gap stalls separators
      applyStimulus(1, 8'h21, 0, 1);
      applyStimulus(1, 8'h22, 0, 1);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      drainCheck("drainFullGap");

      // Asynchronous reset mid-frame
      applyStimulus(1, 8'h31, 0, 1);
      applyStimulus(1, 8'h32, 0, 1);
      dv0 = 1'b1; rxd0 = 8'h33;
      #5;
      rst = 1'b1;
      #1;
      checkOutput("asyncRstWrEn", {8'h00, wrEn0}, 9'h000);
      checkOutput("asyncRstDin", din0, 9'h000);
      dv0 = 1'b0; rxd0 = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(1, 8'h41, 0, 1);
      applyStimulus(1, 8'h42, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      drainCheck("drainAfterReset");

      // Gap=0 instance: no separators at all
      applyStimulus1(1, 8'h61, 1);
      applyStimulus1(1, 8'h62, 1);
      applyStimulus1(1, 8'h63, 1);
      applyStimulus1(0, 8'h00, 0);
      applyStimulus1(0, 8'h00, 0);
      applyStimulus1(0, 8'h00, 0);
      drainCheck("drainGapZero");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/gmii2fifo9.md
GMII2FIFO9 -- requirements
Module: gmii2fifo9

Interface
REQ-001 SHALL provide parameter Gap, 4 bits, default 4'h2: number of separator words written after each frame.
REQ-002 SHALL provide input gmii_rx_clk, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-003 SHALL provide input sys_rst, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide input gmii_rx_dv, 1 bit: GMII receive data valid.
REQ-005 SHALL provide input gmii_rxd, 8 bits: GMII receive data byte.
REQ-006 SHALL provide output din, 9 bits: FIFO write word, {flag, byte}.
REQ-007 SHALL provide input full, 1 bit: FIFO full indication, sampled on gmii_rx_clk.
REQ-008 SHALL provide output wr_en, 1 bit: FIFO write enable, one write per asserted cycle.
REQ-009 SHALL provide output wr_clk, 1 bit: FIFO write clock, combinationally equal to gmii_rx_clk.

Function
REQ-010 din and wr_en SHALL be registered; latency from a sampled input to the corresponding write SHALL be exactly 1 gmii_rx_clk cycle.
REQ-011 The block SHALL have three states: IDLE, FRAME and DROP. It SHALL also have a 4-bit gap counter gap_cnt.
REQ-012 In any state, when gmii_rx_dv=1 and full=0 and the state is not DROP:
- din <= {1'b1, gmii_rxd}
- wr_en <= 1
- gap_cnt <= Gap
- state <= FRAME
REQ-013 When gmii_rx_dv=0, gap_cnt!=0 and full=0:
- din <= 9'h000
- wr_en <= 1
- gap_cnt <= gap_cnt-1
REQ-014 When gmii_rx_dv=0 and gap_cnt=0: wr_en <= 0, din holds its value, state <= IDLE.
REQ-015 Overflow: when full=1 and gmii_rx_dv=1:
- wr_en <= 0
- state <= DROP
- the byte is discarded
REQ-016 In DROP, all bytes with gmii_rx_dv=1 SHALL be discarded with wr_en=0, even if full deasserts.
REQ-017 DROP SHALL be left on the first cycle with gmii_rx_dv=0. That cycle SHALL be treated per REQ-013 / REQ-014, with gap_cnt reloaded to Gap on DROP entry. A truncated frame is therefore still terminated by separators.
REQ-018 When full=1 and gmii_rx_dv=0: wr_en <= 0, and gap_cnt and state SHALL be held. Separator emission resumes when full=0.
REQ-019 With Gap=0, no separator words SHALL be written.
REQ-020 gmii_rx_dv reasserting while gap_cnt!=0 SHALL start a new frame immediately per REQ-012 and reload gap_cnt. Separators SHALL be emitted only after that new frame ends.
REQ-021 Preamble and SFD bytes SHALL be passed through unmodified. The block SHALL perform no CRC check and no error handling.
REQ-022 gap_cnt decrement SHALL never wrap below 0.

Reset
REQ-023 While sys_rst=1, independent of the clock:
- wr_en=0
- din=9'h000
- gap_cnt=0
- state=IDLE
REQ-024 Reset asserted mid-frame SHALL abort the frame with no separators. The first write after reset release SHALL occur only on a new gmii_rx_dv=1 cycle.
REQ-025 wr_clk SHALL follow gmii_rx_clk during reset.

Verification
REQ-026 Frame of bytes 55,55,D5,01,02 (dv=1, full=0, Gap=2) -> five writes 155,155,1D5,101,102, then two writes 000,000, then wr_en=0. First write is one cycle after the first dv cycle.
REQ-027 Two frames separated by a single dv=0 cycle (Gap=2) -> exactly one 000 write between them. The second frame's 1xx words are contiguous and are followed by two 000 writes.
REQ-028 full=1 on the 3rd byte of a 6-byte frame, released on the 4th -> first two bytes written, bytes 3-6 dropped, then two 000 writes after dv falls.
REQ-029 full=1 held for 3 cycles after dv falls (Gap=2) -> wr_en=0 for those 3 cycles, then 000,000 written.
REQ-030 sys_rst pulsed asynchronously mid-frame -> wr_en=0 and din=000 immediately. No separators follow. The next frame is written normally.
REQ-031 Parameter Gap=0 with a 3-byte frame -> exactly three 1xx writes and no 000 writes.
